// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
package cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bit index counter width; cnt only ever holds WIDTH-1 down to 0.
   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/bit_cmp.sv
// Single-bit greater/less cell.
module bit_cmp (
   input  logic x,
   input  logic y,
   output logic g,
   output logic l
);

   assign g = x & ~y;
   assign l = ~x & y;

endmodule

// File: rtl/serial_mag_compare.sv
// Bit-serial MSB-first unsigned magnitude comparator with registered gt/lt/eq
// flags and a one-cycle done pulse; fixed latency of WIDTH+1 cycles.
module serial_mag_compare
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb;
   logic [CW-1:0]    cnt;
   logic             decided, gt_acc, lt_acc;
   logic             g, l, gt_nx, lt_nx;
   logic             accept, last;

   bit_cmp u_cell (
      .x (sa[WIDTH-1]),
      .y (sb[WIDTH-1]),
      .g (g),
      .l (l)
   );

   assign accept = start & ((state == ST_IDLE) | (state == ST_DONE));
   assign last   = (cnt == '0);
   // First differing bit wins; later bits are masked once decided is set.
   assign gt_nx  = gt_acc | (~decided & g);
   assign lt_nx  = lt_acc | (~decided & l);

   assign busy = (state == ST_SHIFT);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_SHIFT;
         ST_SHIFT: if (last)  state_nx = ST_DONE;
         ST_DONE:  state_nx = start ? ST_SHIFT : ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa      <= '0;
         sb      <= '0;
         cnt     <= '0;
         decided <= 1'b0;
         gt_acc  <= 1'b0;
         lt_acc  <= 1'b0;
         gt      <= 1'b0;
         lt      <= 1'b0;
         eq      <= 1'b0;
      end else if (accept) begin
         sa      <= a;
         sb      <= b;
         cnt     <= CW'(WIDTH - 1);
         decided <= 1'b0;
         gt_acc  <= 1'b0;
         lt_acc  <= 1'b0;
      end else if (state == ST_SHIFT) begin
         sa      <= {sa[WIDTH-2:0], 1'b0};
         sb      <= {sb[WIDTH-2:0], 1'b0};
         cnt     <= cnt - CW'(1);
         decided <= decided | g | l;
         gt_acc  <= gt_nx;
         lt_acc  <= lt_nx;
         // Result flags are loaded only on the edge that enters DONE.
         if (last) begin
            gt <= gt_nx;
            lt <= lt_nx;
            eq <= ~(gt_nx | lt_nx);
         end
      end
   end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed bench for serial_mag_compare at WIDTH=8.
module tb_serial_mag_compare;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             busy, done, gt, lt, eq;

   int checks = 0;
   int errors = 0;

   serial_mag_compare #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .gt    (gt),
      .lt    (lt),
      .eq    (eq)
   );

   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00;
      tick(); tick();
      checks++;
      if ({busy, done, gt, lt, eq} !== 5'b00000) begin
         errors++;
         $display("FAIL reset: {busy,done,gt,lt,eq} got %b want 00000", {busy, done, gt, lt, eq});
      end
      rst = 1'b0; start = 1'b0;
      tick();
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle: {busy,done} got %b want 00", {busy, done});
      end
   endtask

   // Table of operands and hand-computed {gt,lt,eq}.
   task automatic test_vectors();
      logic [7:0] va [5] = '{8'hA5, 8'h3C, 8'h7F, 8'h00, 8'hFF};
      logic [7:0] vb [5] = '{8'h5A, 8'h3C, 8'h80, 8'h01, 8'hFE};
      logic [2:0] vf [5] = '{3'b100, 3'b001, 3'b010, 3'b010, 3'b100};
      logic [2:0] prev = 3'b000;
      for (int v = 0; v < 5; v++) begin
         start = 1'b1; a = va[v]; b = vb[v];
         tick();
         start = 1'b0; a = 8'h00; b = 8'h00;
         for (int c = 1; c <= WIDTH; c++) begin
            checks++;
            if ({busy, done, gt, lt, eq} !== {2'b10, prev}) begin
               errors++;
               $display("FAIL vec%0d_cycle%0d: {busy,done,gt,lt,eq} got %b want %b",
                        v, c, {busy, done, gt, lt, eq}, {2'b10, prev});
            end
            tick();
         end
         checks++;
         if ({busy, done, gt, lt, eq} !== {2'b01, vf[v]}) begin
            errors++;
            $display("FAIL vec%0d_done: {busy,done,gt,lt,eq} got %b want %b",
                     v, {busy, done, gt, lt, eq}, {2'b01, vf[v]});
         end
         prev = vf[v];
         tick();
         checks++;
         if ({busy, done, gt, lt, eq} !== {2'b00, prev}) begin
            errors++;
            $display("FAIL vec%0d_idle: {busy,done,gt,lt,eq} got %b want %b",
                     v, {busy, done, gt, lt, eq}, {2'b00, prev});
         end
      end
   endtask

   task automatic test_start_ignored();
      int ndone = 0;
      start = 1'b1; a = 8'hA5; b = 8'h5A;
      tick();
      start = 1'b0;
      for (int c = 1; c < 9; c++) begin
         if (c == 3) begin start = 1'b1; a = 8'h01; b = 8'h02; end
         else        begin start = 1'b0; a = 8'h00; b = 8'h00; end
         tick();
      end
      start = 1'b0;
      checks++;
      if ({done, gt, lt, eq} !== 4'b1100) begin
         errors++;
         $display("FAIL ignore_done: {done,gt,lt,eq} got %b want 1100", {done, gt, lt, eq});
      end
      for (int c = 10; c < 22; c++) begin
         tick();
         if (done || busy) ndone++;
      end
      checks++;
      if (ndone !== 0) begin
         errors++;
         $display("FAIL ignore_no_second: busy/done cycles got %0d want 0", ndone);
      end
   endtask

   task automatic test_mid_reset();
      int nact = 0;
      start = 1'b1; a = 8'hA5; b = 8'h5A;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({busy, done, gt, lt, eq} !== 5'b00000) begin
         errors++;
         $display("FAIL midrst: {busy,done,gt,lt,eq} got %b want 00000", {busy, done, gt, lt, eq});
      end
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done || busy) nact++;
      end
      checks++;
      if (nact !== 0) begin
         errors++;
         $display("FAIL midrst_no_done: busy/done cycles got %0d want 0", nact);
      end
      start = 1'b1; a = 8'h10; b = 8'h20;
      tick();
      start = 1'b0;
      for (int c = 1; c < 9; c++) tick();
      checks++;
      if ({busy, done, gt, lt, eq} !== 5'b01010) begin
         errors++;
         $display("FAIL midrst_rerun: {busy,done,gt,lt,eq} got %b want 01010", {busy, done, gt, lt, eq});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      start = 1'b1; a = 8'h00; b = 8'h01;
      tick();
      start = 1'b0;
      for (int c = 1; c < 9; c++) tick();
      checks++;
      if ({busy, done, gt, lt, eq} !== 5'b01010) begin
         errors++;
         $display("FAIL b2b_first: {busy,done,gt,lt,eq} got %b want 01010", {busy, done, gt, lt, eq});
      end
      start = 1'b1; a = 8'h80; b = 8'h7F;
      tick();
      start = 1'b0; a = 8'h00; b = 8'h00;
      for (int c = 10; c < 18; c++) begin
         checks++;
         if ({busy, done, gt, lt, eq} !== 5'b10010) begin
            errors++;
            $display("FAIL b2b_cycle%0d: {busy,done,gt,lt,eq} got %b want 10010", c, {busy, done, gt, lt, eq});
         end
         tick();
      end
      checks++;
      if ({busy, done, gt, lt, eq} !== 5'b01100) begin
         errors++;
         $display("FAIL b2b_second: {busy,done,gt,lt,eq} got %b want 01100", {busy, done, gt, lt, eq});
      end
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      test_reset();
      test_vectors();
      test_start_ignored();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
